// File: rtl/branch_pkg.sv
// Shared opcodes, PC mux encodings, BHT counter type and FSM states for the
// branch resolution unit and its prediction table.
package branch_pkg;

   localparam logic [3:0] OP_BE  = 4'b0100;
   localparam logic [3:0] OP_BNE = 4'b0101;
   localparam logic [3:0] OP_BLT = 4'b0110;
   localparam logic [3:0] OP_BGE = 4'b0111;
   localparam logic [3:0] OP_J   = 4'b1000;

   localparam logic [1:0] SEL_PC1      = 2'b00;
   localparam logic [1:0] SEL_TARGET   = 2'b01;
   localparam logic [1:0] SEL_FALLTHRU = 2'b10;

   typedef logic [1:0] bht_ctr_t;
   localparam bht_ctr_t BHT_WNT = 2'b01;

   typedef enum logic {IDLE, FLUSH} state_t;

   // Two-bit saturating counter step: taken counts up, not-taken counts down.
   function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
      bht_ctr_t res;
      res = ctr;
      if (taken && ctr != 2'b11)
         res = ctr + 2'b01;
      else if (!taken && ctr != 2'b00)
         res = ctr - 2'b01;
      return res;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: asynchronous read for
// fetch, synchronous saturating update from execute, resets to weakly not-taken.
module bht_2bit
   import branch_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_ctr_t         rd_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   bht_ctr_t entries_q [DEPTH];

   // No write-to-read bypass: a same-cycle fetch of the updated index sees the old counter.
   assign rd_ctr = entries_q[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            entries_q[i] <= BHT_WNT;
      end else if (upd_en) begin
         entries_q[upd_idx] <= bht_next(entries_q[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolution: evaluates the branch, checks the fetch
// prediction, drives a one-cycle PC redirect and a flush window, keeps stats.
module branch_unit
   import branch_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int PC_W         = 16,
   parameter int BHT_DEPTH    = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              predict_taken,
   input  logic              ex_valid,
   input  logic [3:0]        opCode,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic              ex_pred_taken,
   input  logic [PC_W-1:0]   ex_target,
   input  logic [DATA_W-1:0] rs1_value,
   input  logic [DATA_W-1:0] rs2_value,
   output logic [1:0]        select_pc_mux,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              flush,
   output logic [15:0]       branch_count,
   output logic [15:0]       mispredict_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t            state, state_next;
   logic [CNT_W-1:0]  flush_cnt, flush_cnt_next;

   logic signed [DATA_W-1:0] rs1_s, rs2_s;
   logic     is_branch;
   logic     actual_taken;
   logic     resolve;
   logic     mispredict;
   bht_ctr_t fetch_ctr;
   logic     unused;

   assign rs1_s = signed'(rs1_value);
   assign rs2_s = signed'(rs2_value);

   always_comb begin
      is_branch    = 1'b1;
      actual_taken = 1'b0;
      case (opCode)
         OP_BE:   actual_taken = (rs1_s == rs2_s);
         OP_BNE:  actual_taken = (rs1_s != rs2_s);
         OP_BLT:  actual_taken = (rs1_s <  rs2_s);
         OP_BGE:  actual_taken = (rs1_s >= rs2_s);
         OP_J:    actual_taken = 1'b1;
         default: is_branch    = 1'b0;
      endcase
   end

   // Anything arriving during the flush window is a squashed wrong-path instruction.
   assign resolve    = ex_valid && (state == IDLE) && is_branch;
   assign mispredict = resolve && (actual_taken != ex_pred_taken);

   bht_2bit #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (fetch_pc[IDX_W-1:0]),
      .rd_ctr    (fetch_ctr),
      .upd_en    (resolve && (opCode != OP_J)),
      .upd_idx   (ex_pc[IDX_W-1:0]),
      .upd_taken (actual_taken)
   );

   assign predict_taken = fetch_ctr[1];
   assign unused        = ^{fetch_pc[PC_W-1:IDX_W], fetch_ctr[0]};

   // ---- resolve (cycle N) -> redirect / stats registers (cycle N+1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         select_pc_mux    <= SEL_PC1;
         redirect_pc      <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         select_pc_mux <= SEL_PC1;
         if (mispredict) begin
            select_pc_mux <= actual_taken ? SEL_TARGET : SEL_FALLTHRU;
            redirect_pc   <= actual_taken ? ex_target : ex_pc + PC_W'(1);
         end
         if (resolve && branch_count != 16'hFFFF)
            branch_count <= branch_count + 16'd1;
         if (mispredict && mispredict_count != 16'hFFFF)
            mispredict_count <= mispredict_count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         flush_cnt <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      case (state)
         IDLE: begin
            if (mispredict) begin
               state_next     = FLUSH;
               flush_cnt_next = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (flush_cnt == '0)
               state_next = IDLE;
            else
               flush_cnt_next = flush_cnt - CNT_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

   assign flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: resolve/redirect timing, BHT training,
// flush-window squashing, wrap of the fall-through PC and mid-flush reset.
module tb_branch_unit;
   import branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] fetch_pc;
   logic        predict_taken;
   logic        ex_valid;
   logic [3:0]  opCode;
   logic [15:0] ex_pc;
   logic        ex_pred_taken;
   logic [15:0] ex_target;
   logic [15:0] rs1_value, rs2_value;
   logic [1:0]  select_pc_mux;
   logic [15:0] redirect_pc;
   logic        flush;
   logic [15:0] branch_count, mispredict_count;

   int compared   = 0;
   int mismatched = 0;

   branch_unit #(
      .DATA_W(16), .PC_W(16), .BHT_DEPTH(16), .FLUSH_CYCLES(2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_pc         (fetch_pc),
      .predict_taken    (predict_taken),
      .ex_valid         (ex_valid),
      .opCode           (opCode),
      .ex_pc            (ex_pc),
      .ex_pred_taken    (ex_pred_taken),
      .ex_target        (ex_target),
      .rs1_value        (rs1_value),
      .rs2_value        (rs2_value),
      .select_pc_mux    (select_pc_mux),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] pc,
                        input logic pred, input logic [15:0] tgt,
                        input logic [15:0] a, input logic [15:0] b);
      ex_valid      = v;
      opCode        = op;
      ex_pc         = pc;
      ex_pred_taken = pred;
      ex_target     = tgt;
      rs1_value     = a;
      rs2_value     = b;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] sel, input logic [15:0] rpc,
                          input logic fl, input logic [15:0] bc, input logic [15:0] mc);
      chk({tag, "_sel"},   32'(select_pc_mux), 32'(sel));
      if (sel != SEL_PC1)
         chk({tag, "_rpc"}, 32'(redirect_pc), 32'(rpc));
      chk({tag, "_flush"}, 32'(flush), 32'(fl));
      chk({tag, "_bcnt"},  32'(branch_count), 32'(bc));
      chk({tag, "_mcnt"},  32'(mispredict_count), 32'(mc));
   endtask

   initial begin
      rst_n    = 1'b0;
      fetch_pc = 16'h0000;
      drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      repeat (2) tick();
      chk("rst_sel",   32'(select_pc_mux), 32'h0);
      chk("rst_rpc",   32'(redirect_pc), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_bcnt",  32'(branch_count), 32'h0);
      chk("rst_mcnt",  32'(mispredict_count), 32'h0);
      rst_n = 1'b1;
      tick();

      // BE taken, predicted not-taken -> redirect to target, 2-cycle flush
      fetch_pc = 16'h0003;
      #1 chk("pred_idx3", 32'(predict_taken), 32'h0);
      drive(1'b1, OP_BE, 16'h0010, 1'b0, 16'h0040, 16'h1234, 16'h1234);
      tick();
      chk_out("be_n1", SEL_TARGET, 16'h0040, 1'b1, 16'd1, 16'd1);
      drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick();
      chk_out("be_n2", SEL_PC1, 16'h0, 1'b1, 16'd1, 16'd1);
      tick();
      chk_out("be_n3", SEL_PC1, 16'h0, 1'b0, 16'd1, 16'd1);
      fetch_pc = 16'h0000;
      #1 chk("pred_idx0_trained", 32'(predict_taken), 32'h1);

      // BLT signed: -1 < 1 taken, predicted taken
      drive(1'b1, OP_BLT, 16'h0022, 1'b1, 16'h0050, 16'hFFFF, 16'h0001);
      tick();
      chk_out("blt", SEL_PC1, 16'h0, 1'b0, 16'd2, 16'd1);

      // BGE signed: -1 >= 1 false, predicted taken at ex_pc 0xFFFF -> wrap to 0
      drive(1'b1, OP_BGE, 16'hFFFF, 1'b1, 16'h0077, 16'hFFFF, 16'h0001);
      tick();
      chk_out("bge_n1", SEL_FALLTHRU, 16'h0000, 1'b1, 16'd3, 16'd2);

      // Mispredicting BE presented during the flush window is squashed
      drive(1'b1, OP_BE, 16'h0006, 1'b0, 16'h0099, 16'h0007, 16'h0007);
      tick();
      chk_out("squash_n2", SEL_PC1, 16'h0, 1'b1, 16'd3, 16'd2);
      tick();
      chk_out("squash_n3", SEL_PC1, 16'h0, 1'b0, 16'd3, 16'd2);
      drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      fetch_pc = 16'h0006;
      #1 chk("pred_idx6_untouched", 32'(predict_taken), 32'h0);
      fetch_pc = 16'h000F;
      #1 chk("pred_idxF_bge_nt", 32'(predict_taken), 32'h0);

      // BNE at 0x0005 trained taken three times (correct predictions)
      fetch_pc = 16'h0015;
      drive(1'b1, OP_BNE, 16'h0005, 1'b1, 16'h0060, 16'h0001, 16'h0002);
      #1 chk("bne_nobypass", 32'(predict_taken), 32'h0);
      tick();
      chk("bne1_pred", 32'(predict_taken), 32'h1);
      tick();
      chk("bne2_pred", 32'(predict_taken), 32'h1);
      tick();
      chk("bne3_pred", 32'(predict_taken), 32'h1);
      chk_out("bne3", SEL_PC1, 16'h0, 1'b0, 16'd6, 16'd2);
      // one not-taken from saturated 11 leaves 10, still predicting taken
      drive(1'b1, OP_BNE, 16'h0005, 1'b0, 16'h0060, 16'h0003, 16'h0003);
      tick();
      chk("bne_sat_pred", 32'(predict_taken), 32'h1);
      chk_out("bne_nt", SEL_PC1, 16'h0, 1'b0, 16'd7, 16'd2);

      // J predicted not-taken: redirect to target, no BHT update
      drive(1'b1, OP_J, 16'h0008, 1'b0, 16'h0123, 16'h0000, 16'h0000);
      tick();
      chk_out("j_n1", SEL_TARGET, 16'h0123, 1'b1, 16'd8, 16'd3);
      drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      fetch_pc = 16'h0008;
      #1 chk("pred_idx8_j", 32'(predict_taken), 32'h0);
      repeat (2) tick();
      chk("j_flush_done", 32'(flush), 32'h0);

      // Non-branch opcode leaves everything unchanged
      drive(1'b1, 4'b0001, 16'h0004, 1'b1, 16'h0200, 16'h0001, 16'h0001);
      tick();
      chk_out("nonbr", SEL_PC1, 16'h0, 1'b0, 16'd8, 16'd3);
      fetch_pc = 16'h0004;
      #1 chk("pred_idx4_nonbr", 32'(predict_taken), 32'h0);

      // Mispredict, then reset mid-flush
      drive(1'b1, OP_BE, 16'h0009, 1'b0, 16'h0300, 16'h0005, 16'h0005);
      tick();
      chk_out("pre_rst", SEL_TARGET, 16'h0300, 1'b1, 16'd9, 16'd4);
      drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_flush", 32'(flush), 32'h0);
      chk("rst_mid_sel",   32'(select_pc_mux), 32'h0);
      chk("rst_mid_bcnt",  32'(branch_count), 32'h0);
      chk("rst_mid_mcnt",  32'(mispredict_count), 32'h0);
      for (int i = 0; i < 16; i++) begin
         fetch_pc = 16'(i);
         #1 chk($sformatf("rst_pred_%0d", i), 32'(predict_taken), 32'h0);
      end
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_flush", 32'(flush), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution unit for the execute stage, with a fetch-side 2-bit branch history table (BHT) predictor. It evaluates BE/BNE/BLT/BGE/J against operand values, compares the outcome with the prediction made at fetch, and drives the PC mux select and redirect target one cycle later. It holds a flush window after every mispredict and keeps saturating branch and mispredict counters.

## Interface
- DATA_W, 16: operand width.
- PC_W, 16: PC and target width.
- BHT_DEPTH, 16: BHT entries; power of two, at least 2. IDX_W = $clog2(BHT_DEPTH).
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict; at least 1.
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_pc  in  PC_W  PC being fetched; index is fetch_pc[IDX_W-1:0].
- predict_taken  out  1  combinational. 1 when BHT[index] is 2'b10 or 2'b11.
- ex_valid  in  1  a valid instruction is in execute this cycle.
- opCode  in  4  opcode of the execute instruction.
- ex_pc  in  PC_W  PC of the execute instruction.
- ex_pred_taken  in  1  prediction the fetch stage made for this instruction.
- ex_target  in  PC_W  taken target, already computed.
- rs1_value, rs2_value  in  DATA_W  operands.
- select_pc_mux  out  2  registered PC mux select: 00 = PC+1, 01 = ex_target (redirect taken), 10 = ex_pc+1 (redirect fall-through).
- redirect_pc  out  PC_W  registered redirect address. Valid when select_pc_mux != 00.
- flush  out  1  registered. High means squash the younger pipeline stages.
- branch_count  out  16  saturating count of resolved branches.
- mispredict_count  out  16  saturating count of mispredicts.

## Operation
- Opcodes:
  - 0100 BE: taken when rs1 == rs2.
  - 0101 BNE: taken when rs1 != rs2.
  - 0110 BLT: taken when rs1 < rs2, two's-complement signed.
  - 0111 BGE: taken when rs1 >= rs2, signed.
  - 1000 J: always taken.
  - Any other opcode is not a branch.
- Resolve condition: ex_valid && state == IDLE && opcode is a branch.
  - In FLUSH state, ex_valid is ignored completely: no BHT update, no counter change, no redirect.
- Mispredict condition: resolve && (actual_taken != ex_pred_taken).
  - actual_taken = 1 gives select 01 with redirect_pc = ex_target.
  - actual_taken = 0 gives select 10 with redirect_pc = ex_pc + 1. The addition wraps modulo 2^PC_W.
- BHT update on resolve for conditional branches only; J does not update.
  - Index is ex_pc[IDX_W-1:0].
  - Counter rule: taken increments, not-taken decrements, saturating at 00 and 11.
- Counters:
  - branch_count increments on every resolve and holds at 16'hFFFF.
  - mispredict_count increments on every mispredict and holds at 16'hFFFF.
- State machine:
  - IDLE to FLUSH on a mispredict; the flush counter is loaded with FLUSH_CYCLES-1.
  - FLUSH decrements the counter each cycle and returns to IDLE in the cycle after it reaches 0.
  - flush = (state == FLUSH).
- Reset values:
  - select_pc_mux = 00, redirect_pc = 0, flush = 0.
  - Both counters = 0, state = IDLE.
  - Every BHT entry = 2'b01 (weakly not-taken).
- Reset mid-flush: flush deasserts asynchronously on rst_n low, and the BHT returns to 01.

## Timing
- predict_taken: zero latency from fetch_pc.
- Resolve in cycle N gives:
  - select_pc_mux/redirect_pc valid in cycle N+1 for exactly one cycle, then back to 00.
  - flush high in cycles N+1 .. N+FLUSH_CYCLES.
  - The first resolvable instruction is in cycle N+FLUSH_CYCLES+1.
- A correct prediction in cycle N leaves select 00 in N+1 and flush 0.
- BHT write lands at the end of cycle N. A fetch read of the same index in cycle N sees the old value; there is no bypass. From N+1 the read sees the new value.
- Resolves in back-to-back cycles without a mispredict each update the BHT and counters in their own cycle.

## Structure
- Package branch_pkg holds:
  - Opcode localparams: OP_BE, OP_BNE, OP_BLT, OP_BGE, OP_J.
  - Select encodings: SEL_PC1, SEL_TARGET, SEL_FALLTHRU.
  - BHT counter type and reset value BHT_WNT = 2'b01.
  - State enum {IDLE, FLUSH}.
- Sub-module bht_2bit holds the table.
  - Parameters DEPTH and IDX_W.
  - One asynchronous read port and one synchronous saturating-update port.
  - Reset to 01 via rst_n.
- branch_unit contains the comparators, the mispredict logic, the FSM and the counters.

## Test plan
- After reset, fetch_pc = 0x0003 gives predict_taken = 0. BE with rs1 = rs2 = 0x1234, ex_pred_taken = 0, ex_target = 0x0040 gives in N+1: select 01, redirect_pc 0x0040. flush is high for 2 cycles, and mispredict_count = 1.
- BLT with rs1 = 0xFFFF (-1), rs2 = 0x0001, ex_pred_taken = 1 gives no redirect, flush = 0, branch_count + 1. BGE with the same operands and ex_pred_taken = 1, ex_pc = 0xFFFF gives select 10 with redirect_pc = 0x0000 (wrap).
- BNE at ex_pc = 0x0005 resolved taken three times with ex_valid kept out of flush windows. The BHT[5] sequence is 01→10→11→11 and predict_taken for fetch_pc = 0x0015 becomes 1 after the first update.
- Mispredict in cycle N, then ex_valid = 1 with a mispredicting BE in N+1 and N+2. The BE is ignored: no counter change, select returns to 00 in N+2, flush clears after N+2.
- rst_n pulsed low mid-flush gives flush = 0 immediately and predict_taken = 0 for all indices afterwards. Non-branch opcode 0001 with ex_valid = 1 leaves all outputs and counters unchanged.
